// File: rtl/raster_step_sequencer_pkg.sv
// Shared constants and encodings for the raster step sequencer and VGA timing.
package raster_step_sequencer_pkg;

    // VGA 640x480 timing, shared with the scan generator.
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_TOTAL  = 800;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_TOTAL  = 525;

    typedef enum logic {
        KIND_FRAME = 1'b0,
        KIND_LINE  = 1'b1
    } step_kind_e;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StIssue   = 2'd1,
        StPending = 2'd2
    } state_e;

endpackage

// File: rtl/raster_step_sequencer_if.sv
// Scan-position inputs, stepper handshake and debug outputs of the step sequencer.
interface raster_step_sequencer_if;
    logic       enable;
    logic [9:0] scan_x;
    logic [9:0] scan_y;
    logic       step_busy;
    logic       frame_step;
    logic       line_step;
    logic [9:0] draw_y;
    logic       overrun;
    logic [7:0] overrun_count;
    logic       pending;

    // Sequencer side: consumes scan position and busy, drives step pulses.
    modport master (
        input  enable, scan_x, scan_y, step_busy,
        output frame_step, line_step, draw_y, overrun, overrun_count, pending
    );

    // Stepper / scan-generator side.
    modport slave (
        output enable, scan_x, scan_y, step_busy,
        input  frame_step, line_step, draw_y, overrun, overrun_count, pending
    );
endinterface

// File: rtl/raster_step_sequencer_sat_counter.sv
// Saturating up-counter with asynchronous active-low reset; sticks at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    // Increment on request unless already at the maximum value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/raster_step_sequencer.sv
// Issues one frame_step per frame and one line_step per visible line from the scan
// position, deferring steps while the stepper is busy and counting overruns.
module raster_step_sequencer #(
    parameter int unsigned H_ACTIVE  = raster_step_sequencer_pkg::H_ACTIVE,
    parameter int unsigned V_ACTIVE  = raster_step_sequencer_pkg::V_ACTIVE,
    parameter int unsigned V_TOTAL   = raster_step_sequencer_pkg::V_TOTAL,
    parameter int unsigned TRIGGER_X = H_ACTIVE
) (
    input  logic                           clk,
    input  logic                           rst_n,
    raster_step_sequencer_if.master        bus
);

    import raster_step_sequencer_pkg::*;

    localparam logic [9:0] TrigX     = 10'(TRIGGER_X);
    localparam logic [9:0] YFrame    = 10'(V_TOTAL - 1);
    localparam logic [9:0] YLastLine = 10'(V_ACTIVE - 2);

    logic       match_q, match_prev_q, trigger;
    logic       classified, trig_valid, overrun_pulse;
    step_kind_e trig_kind, kind_q, kind_d;
    logic [9:0] trig_target, target_q, target_d, draw_y_q;
    state_e     state_q, state_d;

    // Edge-detect the registered x match so each line triggers once even though
    // scan_x holds for two clocks per pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_q      <= 1'b0;
            match_prev_q <= 1'b0;
        end else begin
            match_q      <= (bus.scan_x == TrigX);
            match_prev_q <= match_q;
        end
    end

    assign trigger = match_q & ~match_prev_q;

    // Decide step kind and target line from scan_y at the trigger.
    always_comb begin
        classified  = 1'b0;
        trig_kind   = KIND_LINE;
        trig_target = '0;
        if (bus.scan_y == YFrame) begin
            classified  = 1'b1;
            trig_kind   = KIND_FRAME;
        end else if (bus.scan_y <= YLastLine) begin
            classified  = 1'b1;
            trig_target = bus.scan_y + 10'd1;
        end
    end

    assign trig_valid = trigger & bus.enable & classified;

    // Next-state logic; a newer trigger always replaces any stored step.
    always_comb begin
        state_d       = state_q;
        kind_d        = kind_q;
        target_d      = target_q;
        overrun_pulse = 1'b0;
        if (trig_valid) begin
            kind_d   = trig_kind;
            target_d = trig_target;
        end
        unique case (state_q)
            StIdle, StIssue: begin
                if (trig_valid) begin
                    state_d       = bus.step_busy ? StPending : StIssue;
                    overrun_pulse = bus.step_busy;
                end else begin
                    state_d = StIdle;
                end
            end
            StPending: begin
                if (!bus.enable) begin
                    state_d = StIdle;
                end else if (trig_valid) begin
                    overrun_pulse = 1'b1;
                    state_d       = bus.step_busy ? StPending : StIssue;
                end else if (!bus.step_busy) begin
                    state_d = StIssue;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, stored step and draw_y; draw_y only changes when entering ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            kind_q   <= KIND_FRAME;
            target_q <= '0;
            draw_y_q <= '0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            target_q <= target_d;
            if (state_d == StIssue) begin
                draw_y_q <= target_d;
            end
        end
    end

    sat_counter #(
        .WIDTH (8)
    ) u_overrun_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (overrun_pulse),
        .count (bus.overrun_count)
    );

    assign bus.frame_step = (state_q == StIssue) && (kind_q == KIND_FRAME);
    assign bus.line_step  = (state_q == StIssue) && (kind_q == KIND_LINE);
    assign bus.draw_y     = draw_y_q;
    assign bus.overrun    = overrun_pulse;
    assign bus.pending    = (state_q == StPending);

endmodule

// File: doc/raster_step_sequencer.md
Name: raster_step_sequencer

Overview:
- Schedules the per-scanline work of the edge stepper and line raster from VGA scan position.
- Issues one frame_step per frame and one line_step per visible line, so line y+1 is drawn while line y is scanned out.
- Detects when the stepper has not finished the previous line (overrun), defers the step, and counts overruns for debug readback over SPI.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- V_TOTAL, 525, total lines per frame (scan_y range 0..V_TOTAL-1)
- TRIGGER_X, 640, scan_x value that fires the per-line trigger (start of hblank)

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  sequencing enable; low suppresses new steps
- scan_x  in  10  current VGA horizontal position
- scan_y  in  10  current VGA vertical position
- step_busy  in  1  stepper still processing previous step
- frame_step  out  1  one-cycle pulse: start new frame (prepare line 0)
- line_step  out  1  one-cycle pulse: draw next line
- draw_y  out  10  line index the current or most recent step targets
- overrun  out  1  one-cycle pulse: trigger arrived while busy or pending
- overrun_count  out  8  saturating overrun counter
- pending  out  1  a step is deferred waiting for step_busy low

Behaviour:
- Reset (async, rst_n low): all outputs 0; state IDLE; match register 0. Takes effect immediately, including mid-PENDING; the deferred step is discarded.
- Trigger: match = (scan_x == TRIGGER_X). Match is registered; trigger = match & ~match_q. This gives exactly one trigger per line, even though scan_x holds for 2 clk per pixel.
- Classification uses scan_y at the trigger cycle:
  - y == V_TOTAL-1 -> FRAME kind, target 0.
  - 0 <= y <= V_ACTIVE-2 -> LINE kind, target y+1.
  - Otherwise -> ignored; no pulse, no overrun.
- Triggers are ignored when enable is low. Deasserting enable while PENDING cancels the pending step.
- States:
  - IDLE:
    - Classified trigger with step_busy low -> ISSUE.
    - Classified trigger with step_busy high -> PENDING; overrun pulse; count += 1.
  - ISSUE (1 cycle): assert frame_step or line_step per kind; draw_y = target; -> IDLE.
  - PENDING:
    - step_busy low -> ISSUE using the stored kind and target.
    - New classified trigger arrives -> stored kind/target replaced by the newer one; overrun pulse; count += 1; stay PENDING.
    - Trigger and busy-low in the same cycle -> the newer trigger wins; go to ISSUE with the newer target.
- Latency: the pulse is asserted 2 clk after the first cycle scan_x == TRIGGER_X is presented (1 for match_q edge detect, 1 registered ISSUE), provided busy is low.
- frame_step and line_step are never asserted together; each is high for at most 1 cycle per trigger.
- draw_y updates only in ISSUE and holds otherwise.
- overrun_count saturates at 255; there is no wrap.
- step_busy is sampled each cycle.

Decomposition:
- Shared package holds:
  - VGA 640x480 timing constants (H_ACTIVE, V_ACTIVE, V_TOTAL, H_TOTAL), also used by the VGA scan generator.
  - Step-kind encoding (KIND_FRAME = 0, KIND_LINE = 1).
  - State encoding (IDLE, ISSUE, PENDING).
- One natural sub-module: sat_counter (8-bit saturating increment with async reset), reusable for other debug counters.
- The rest is a single flat FSM.

Test Plan:
- Reset: rst_n low with random inputs -> all outputs 0. Release rst_n, hold scan_x = 0 -> outputs stay 0.
- Frame trigger: scan_y = 524, scan_x steps 639 -> 640 (held 2 clk) -> 641; busy low -> exactly one frame_step pulse 2 clk after x = 640 first appears; draw_y = 0; no line_step.
- Line triggers:
  - y = 10, x -> 640 -> line_step, draw_y = 11.
  - y = 478 -> draw_y = 479.
  - y = 479 and y = 500 -> no pulse, no overrun.
  - enable low at y = 12 -> no pulse.
- Overrun deferral: y = 20 trigger with step_busy high; busy falls 3 clk later -> overrun pulse at the trigger, count = 1, pending high. line_step appears the cycle after busy is seen low, with draw_y = 21.
- Replace and saturation:
  - While PENDING for y = 20, trigger at y = 21 -> count = 2; the eventual line_step has draw_y = 22; only one step is issued.
  - Force 300 overruns -> count = 255.
- Async reset mid-PENDING: assert rst_n low while pending = 1 -> outputs 0 immediately, not at the clock edge. After release and busy low, no stale step is issued.
